anita3_phi_coincidence: RTL and testbench

- Consumes the masked, registered per-phi L1 outputs of the phi-sector trigger map: 16 V-pol and 16 H-pol bits at 250 MHz.
- Stretches each sector's rising edges into a programmable window and forms an L3 per sector: a sector fires when it and at least one azimuthal neighbour overlap. Sector adjacency wraps 15↔0.
- A holdoff state machine issues a single-cycle global trigger with a latched phi pattern, and maintains a saturating trigger counter for readout.

---
 rtl/anita3_phi_coincidence.sv | 148 ++++++++++++++
 tb/tb_anita3_phi_coincidence.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/anita3_phi_coincidence.sv
// ANITA-3 phi-sector coincidence: per-sector edge stretch, neighbour-overlap L3,
// and a holdoff-gated global trigger with latched pattern and saturating count.

module anita3_phi_stretch #(
  parameter int WINDOW_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in,
  input  logic [WINDOW_BITS-1:0] window,
  output logic                   stretch
);
  logic                   prev;
  logic [WINDOW_BITS-1:0] cnt;
  logic                   rise;

  assign rise = in & ~prev;

  // window is captured only on a rise, so mid-pulse changes never reshape it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev    <= 1'b0;
      cnt     <= '0;
      stretch <= 1'b0;
    end else begin
      prev <= in;
      if (rise) begin
        stretch <= 1'b1;
        cnt     <= window;
      end else if (cnt != '0) begin
        cnt <= cnt - WINDOW_BITS'(1);
      end else begin
        stretch <= 1'b0;
      end
    end
  end
endmodule

module anita3_phi_coincidence #(
  parameter int NUM_PHI      = 16,
  parameter int WINDOW_BITS  = 4,
  parameter int HOLDOFF_BITS = 6
) (
  input  logic                    clk250_i,
  input  logic                    rst_n_i,
  input  logic [NUM_PHI-1:0]      V_pol_phi_i,
  input  logic [NUM_PHI-1:0]      H_pol_phi_i,
  input  logic [WINDOW_BITS-1:0]  window_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic [1:0]              pol_en_i,
  input  logic                    disable_i,
  input  logic                    count_clr_i,
  output logic [NUM_PHI-1:0]      L3_V_o,
  output logic [NUM_PHI-1:0]      L3_H_o,
  output logic                    trig_o,
  output logic [NUM_PHI-1:0]      trig_phi_o,
  output logic [31:0]             trig_count_o
);
  typedef enum logic {IDLE, HOLDOFF} state_t;

  logic [NUM_PHI-1:0]      s_v, s_h;
  logic [NUM_PHI-1:0]      pattern;
  logic                    cand, fire;
  state_t                  state, state_d;
  logic [HOLDOFF_BITS-1:0] hcnt, hcnt_d;

  for (genvar g = 0; g < NUM_PHI; g++) begin : gen_phi
    anita3_phi_stretch #(.WINDOW_BITS(WINDOW_BITS)) u_str_v (
      .clk     (clk250_i),
      .rst_n   (rst_n_i),
      .in      (V_pol_phi_i[g]),
      .window  (window_i),
      .stretch (s_v[g])
    );
    anita3_phi_stretch #(.WINDOW_BITS(WINDOW_BITS)) u_str_h (
      .clk     (clk250_i),
      .rst_n   (rst_n_i),
      .in      (H_pol_phi_i[g]),
      .window  (window_i),
      .stretch (s_h[g])
    );
  end

  // Sector j overlaps with j-1 or j+1; rotations give the 15<->0 wrap for free
  function automatic logic [NUM_PHI-1:0] coinc(input logic [NUM_PHI-1:0] s);
    logic [NUM_PHI-1:0] lo, hi;
    lo = {s[NUM_PHI-2:0], s[NUM_PHI-1]};
    hi = {s[0], s[NUM_PHI-1:1]};
    return s & (lo | hi);
  endfunction

  always_ff @(posedge clk250_i) begin
    if (!rst_n_i) begin
      L3_V_o <= '0;
      L3_H_o <= '0;
    end else begin
      L3_V_o <= coinc(s_v);
      L3_H_o <= coinc(s_h);
    end
  end

  always_comb begin
    pattern = (pol_en_i[0] ? L3_V_o : '0) | (pol_en_i[1] ? L3_H_o : '0);
    cand    = |pattern;
  end

  always_ff @(posedge clk250_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      hcnt  <= '0;
    end else begin
      state <= state_d;
      hcnt  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state;
    hcnt_d  = hcnt;
    case (state)
      IDLE: if (fire) begin
        state_d = HOLDOFF;
        hcnt_d  = holdoff_i;
      end
      HOLDOFF: if (hcnt != '0) hcnt_d = hcnt - HOLDOFF_BITS'(1);
               else            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Activity seen in HOLDOFF is dropped, not queued
  always_comb begin
    fire = (state == IDLE) & cand & ~disable_i;
  end

  always_ff @(posedge clk250_i) begin
    if (!rst_n_i) begin
      trig_o       <= 1'b0;
      trig_phi_o   <= '0;
      trig_count_o <= '0;
    end else begin
      trig_o <= fire;
      if (fire) trig_phi_o <= pattern;
      if (count_clr_i)                        trig_count_o <= '0;
      else if (fire && trig_count_o != '1)    trig_count_o <= trig_count_o + 32'd1;
    end
  end
endmodule

// File: tb/tb_anita3_phi_coincidence.sv
// Directed bench for anita3_phi_coincidence; inputs change 1 ns after each
// rising edge and outputs are observed at that same point.

module tb_anita3_phi_coincidence;
  logic        clk;
  logic        rst_n;
  logic [15:0] v_pol, h_pol;
  logic [3:0]  window;
  logic [5:0]  holdoff;
  logic [1:0]  pol_en;
  logic        dis, clr;
  logic [15:0] l3_v, l3_h, trig_phi;
  logic        trig;
  logic [31:0] trig_count;

  int checks   = 0;
  int failures = 0;

  anita3_phi_coincidence dut (
    .clk250_i     (clk),
    .rst_n_i      (rst_n),
    .V_pol_phi_i  (v_pol),
    .H_pol_phi_i  (h_pol),
    .window_i     (window),
    .holdoff_i    (holdoff),
    .pol_en_i     (pol_en),
    .disable_i    (dis),
    .count_clr_i  (clr),
    .L3_V_o       (l3_v),
    .L3_H_o       (l3_h),
    .trig_o       (trig),
    .trig_phi_o   (trig_phi),
    .trig_count_o (trig_count)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    v_pol = '0;
    h_pol = '0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v_pol = 16'hFFFF; h_pol = '0; window = 4'd3; holdoff = 6'd10;
    pol_en = 2'b01; dis = 1'b0; clr = 1'b0;
    repeat (5) step();
    checks++; if (l3_v !== 16'h0) begin failures++; $display("FAIL reset_l3_v got=%h exp=0000", l3_v); end
    checks++; if (l3_h !== 16'h0) begin failures++; $display("FAIL reset_l3_h got=%h exp=0000", l3_h); end
    checks++; if (trig !== 1'b0) begin failures++; $display("FAIL reset_trig got=%b exp=0", trig); end
    checks++; if (trig_phi !== 16'h0) begin failures++; $display("FAIL reset_trig_phi got=%h exp=0000", trig_phi); end
    checks++; if (trig_count !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", trig_count); end
    rst_n = 1'b1;
    step();
    checks++; if (l3_v !== 16'h0 || trig !== 1'b0) begin failures++; $display("FAIL release_e1 l3_v=%h trig=%b exp=0000/0", l3_v, trig); end
    step();
    checks++; if (l3_v !== 16'hFFFF || trig !== 1'b0) begin failures++; $display("FAIL release_e2 l3_v=%h trig=%b exp=ffff/0", l3_v, trig); end
    step();
    checks++; if (trig !== 1'b1) begin failures++; $display("FAIL release_trig got=%b exp=1", trig); end
    checks++; if (trig_phi !== 16'hFFFF) begin failures++; $display("FAIL release_phi got=%h exp=ffff", trig_phi); end
    checks++; if (trig_count !== 32'd1) begin failures++; $display("FAIL release_count got=%0d exp=1", trig_count); end
    step();
    checks++; if (trig !== 1'b0) begin failures++; $display("FAIL release_single got=%b exp=0", trig); end
    settle(20);
    clr = 1'b1; step(); clr = 1'b0;
    checks++; if (trig_count !== 32'd0) begin failures++; $display("FAIL count_clear got=%0d exp=0", trig_count); end
  endtask

  task automatic test_basic_wrap();
    int pulses = 0;
    window = 4'd3; holdoff = 6'd10; pol_en = 2'b01;
    v_pol = 16'h0001; step(); pulses += int'(trig);
    v_pol = 16'h0000; step(); pulses += int'(trig);
    v_pol = 16'h8000; step(); pulses += int'(trig);
    v_pol = 16'h0000; step(); pulses += int'(trig);
    checks++; if (l3_v !== 16'h8001) begin failures++; $display("FAIL wrap_l3 got=%h exp=8001", l3_v); end
    step();
    checks++; if (trig !== 1'b1) begin failures++; $display("FAIL wrap_trig got=%b exp=1", trig); end
    checks++; if (trig_phi !== 16'h8001) begin failures++; $display("FAIL wrap_phi got=%h exp=8001", trig_phi); end
    checks++; if (trig_count !== 32'd1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", trig_count); end
    pulses += int'(trig);
    repeat (20) begin step(); pulses += int'(trig); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL wrap_once got=%0d exp=1", pulses); end
    settle(20);
  endtask

  task automatic test_window();
    int pulses = 0;
    int hi = 0;
    logic [15:0] seen = '0;
    window = 4'd2; holdoff = 6'd2; pol_en = 2'b01;
    v_pol = 16'h0010; step();
    v_pol = 16'h0000; step();
    v_pol = 16'h0020; step();
    v_pol = 16'h0000; step();
    checks++; if (l3_v !== 16'h0030) begin failures++; $display("FAIL window_sep2_l3 got=%h exp=0030", l3_v); end
    step();
    checks++; if (trig !== 1'b1) begin failures++; $display("FAIL window_sep2_trig got=%b exp=1", trig); end
    settle(15);
    v_pol = 16'h0010; step(); seen |= l3_v; pulses += int'(trig);
    v_pol = 16'h0000; step(); seen |= l3_v; pulses += int'(trig);
    step(); seen |= l3_v; pulses += int'(trig);
    v_pol = 16'h0020; step(); seen |= l3_v; pulses += int'(trig);
    v_pol = 16'h0000;
    repeat (8) begin step(); seen |= l3_v; pulses += int'(trig); end
    checks++; if (seen !== 16'h0) begin failures++; $display("FAIL window_sep3_l3 got=%h exp=0000", seen); end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL window_sep3_trig got=%0d exp=0", pulses); end
    settle(15);
    v_pol = 16'h0010; step(); hi += int'(dut.gen_phi[4].u_str_v.stretch);
    v_pol = 16'h0000;
    repeat (8) begin step(); hi += int'(dut.gen_phi[4].u_str_v.stretch); end
    checks++; if (hi !== 3) begin failures++; $display("FAIL window_stretch_len got=%0d exp=3", hi); end
    settle(10);
  endtask

  task automatic test_holdoff();
    int exp_pulses[2] = '{4, 11};
    int exp_second[2] = '{9, 4};
    int exp_last[2]   = '{23, 22};
    window = 4'd3; pol_en = 2'b01;
    for (int k = 0; k < 2; k++) begin
      int first = -1, second = -1, last = -1, pulses = 0;
      holdoff = (k == 0) ? 6'd5 : 6'd0;
      settle(80);
      for (int i = 0; i < 30; i++) begin
        v_pol = (i < 20 && i % 2 == 0) ? 16'h0003 : 16'h0000;
        step();
        if (trig) begin
          if (first < 0) first = i;
          else if (second < 0) second = i;
          last = i;
          pulses++;
        end
      end
      checks++; if (first !== 2) begin failures++; $display("FAIL holdoff%0d_first got=%0d exp=2", k, first); end
      checks++; if (second !== exp_second[k]) begin failures++; $display("FAIL holdoff%0d_second got=%0d exp=%0d", k, second, exp_second[k]); end
      checks++; if (pulses !== exp_pulses[k]) begin failures++; $display("FAIL holdoff%0d_pulses got=%0d exp=%0d", k, pulses, exp_pulses[k]); end
      checks++; if (last !== exp_last[k]) begin failures++; $display("FAIL holdoff%0d_last got=%0d exp=%0d", k, last, exp_last[k]); end
    end
    settle(80);
  endtask

  task automatic test_enables();
    int pulses = 0;
    window = 4'd3; holdoff = 6'd2; pol_en = 2'b01;
    h_pol = 16'h0180; step(); pulses += int'(trig);
    h_pol = 16'h0000; step(); pulses += int'(trig);
    checks++; if (l3_h !== 16'h0180) begin failures++; $display("FAIL en_l3_h got=%h exp=0180", l3_h); end
    checks++; if (l3_v !== 16'h0000) begin failures++; $display("FAIL en_l3_v got=%h exp=0000", l3_v); end
    repeat (10) begin step(); pulses += int'(trig); end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL en_vonly_trig got=%0d exp=0", pulses); end
    settle(10);
    pol_en = 2'b10;
    h_pol = 16'h0180; step();
    h_pol = 16'h0000; step(); step();
    checks++; if (trig !== 1'b1) begin failures++; $display("FAIL en_h_trig got=%b exp=1", trig); end
    checks++; if (trig_phi !== 16'h0180) begin failures++; $display("FAIL en_h_phi got=%h exp=0180", trig_phi); end
    settle(10);
    pulses = 0; dis = 1'b1;
    h_pol = 16'h0180; step(); pulses += int'(trig);
    h_pol = 16'h0000;
    repeat (12) begin step(); pulses += int'(trig); end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL en_disable_trig got=%0d exp=0", pulses); end
    dis = 1'b0; pol_en = 2'b01;
    settle(10);
  endtask

  task automatic test_counter();
    window = 4'd3; holdoff = 6'd2; pol_en = 2'b01;
    settle(10);
    force dut.trig_count_o = 32'hFFFF_FFFE;
    #1;
    release dut.trig_count_o;
    v_pol = 16'h0003; step(); v_pol = 16'h0000; step(); step();
    checks++; if (trig !== 1'b1 || trig_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL count_sat1 trig=%b count=%h exp=1/ffffffff", trig, trig_count); end
    settle(10);
    v_pol = 16'h0003; step(); v_pol = 16'h0000; step(); step();
    checks++; if (trig !== 1'b1 || trig_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL count_sat2 trig=%b count=%h exp=1/ffffffff", trig, trig_count); end
    settle(10);
    v_pol = 16'h0003; step(); v_pol = 16'h0000; step();
    clr = 1'b1; step(); clr = 1'b0;
    checks++; if (trig !== 1'b1 || trig_count !== 32'd0) begin failures++; $display("FAIL count_clr_wins trig=%b count=%h exp=1/0", trig, trig_count); end
    settle(10);
    checks++; if (trig_count !== 32'd0) begin failures++; $display("FAIL count_hold got=%h exp=0", trig_count); end
  endtask

  initial begin
    test_reset();
    test_basic_wrap();
    test_window();
    test_holdoff();
    test_enables();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
